// File: rtl/wb_seg.sv
// Write-back stage: WB pipeline register, destination decode, 32x32 register file, retire counter.
// Optional WB_BYPASS_EN: read ports return the pending write-back data in the same cycle.
module wb_seg #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      ALUo_In_i,
    input  logic [31:0]      LMD_i,
    input  logic [31:0]      IR_i,
    input  logic [4:0]       rs_addr,
    input  logic [4:0]       rt_addr,
    output logic [31:0]      rs_data,
    output logic [31:0]      rt_data,
    output logic             wb_we,
    output logic [4:0]       wb_addr,
    output logic [31:0]      wb_data,
    output logic [CNT_W-1:0] retire_cnt
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned NREG = 32;
    localparam int unsigned OPW  = 6;

    localparam logic [OPW-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPW-1:0] OP_LW    = 6'b100011;
    localparam logic [2:0]     OP_IMM_HI = 3'b001;

    logic [XLEN-1:0] alu_q;
    logic [XLEN-1:0] lmd_q;
    logic [XLEN-1:0] ir_q;
    logic [XLEN-1:0] regs [NREG];

    logic [OPW-1:0]  op;
    logic            dec_write;
    logic [AW-1:0]   dec_dest;
    logic [XLEN-1:0] dec_data;

    // Stage register captures every cycle; no stall path.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_q <= '0;
            lmd_q <= '0;
            ir_q  <= '0;
        end else begin
            alu_q <= ALUo_In_i;
            lmd_q <= LMD_i;
            ir_q  <= IR_i;
        end
    end

    // Destination/source decode; non-writing opcodes still drive defined values.
    always_comb begin
        op        = ir_q[31:26];
        dec_write = 1'b0;
        dec_dest  = ir_q[20:16];
        dec_data  = alu_q;
        if (op == OP_RTYPE) begin
            dec_write = 1'b1;
            dec_dest  = ir_q[15:11];
        end else if (op == OP_LW) begin
            dec_write = 1'b1;
            dec_data  = lmd_q;
        end else if (op[5:3] == OP_IMM_HI) begin
            dec_write = 1'b1;
        end
    end

    assign wb_we   = dec_write && (dec_dest != AW'(0));
    assign wb_addr = dec_dest;
    assign wb_data = dec_data;

    // Register file; entry 0 is never written because wb_we excludes dest 0.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NREG); i++) begin
                regs[i] <= '0;
            end
        end else if (wb_we) begin
            regs[wb_addr] <= wb_data;
        end
    end

    // Retire counter: NOP (IR==0) does not count.
    always_ff @(posedge clk) begin
        if (rst) begin
            retire_cnt <= '0;
        end else if (ir_q != XLEN'(0)) begin
            retire_cnt <= retire_cnt + CNT_W'(1);
        end
    end

    // Read ports.
    always_comb begin
        rs_data = (rs_addr == AW'(0)) ? XLEN'(0) : regs[rs_addr];
        rt_data = (rt_addr == AW'(0)) ? XLEN'(0) : regs[rt_addr];
`ifdef WB_BYPASS_EN
        if (wb_we && (rs_addr == wb_addr)) begin
            rs_data = wb_data;
        end
        if (wb_we && (rt_addr == wb_addr)) begin
            rt_data = wb_data;
        end
`endif
    end

endmodule

// File: tb/tb_wb_seg.sv
// Directed bench for wb_seg: vector table for decode/write-back plus reset, bypass and wrap sequences.
module tb_wb_seg;

    localparam int unsigned CNT_W = 4;

    logic             clk;
    logic             rst;
    logic [31:0]      alu_in;
    logic [31:0]      lmd_in;
    logic [31:0]      ir_in;
    logic [4:0]       rs_addr;
    logic [4:0]       rt_addr;
    logic [31:0]      rs_data;
    logic [31:0]      rt_data;
    logic             wb_we;
    logic [4:0]       wb_addr;
    logic [31:0]      wb_data;
    logic [CNT_W-1:0] retire_cnt;

    int unsigned n_pass;
    int unsigned n_total;
    logic [CNT_W-1:0] exp_cnt;

    wb_seg #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .ALUo_In_i  (alu_in),
        .LMD_i      (lmd_in),
        .IR_i       (ir_in),
        .rs_addr    (rs_addr),
        .rt_addr    (rt_addr),
        .rs_data    (rs_data),
        .rt_data    (rt_data),
        .wb_we      (wb_we),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .retire_cnt (retire_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ir;
        logic [31:0] alu;
        logic [31:0] lmd;
        logic        we;
        logic        chk_ad;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [4:0]  rd;
        logic [31:0] rd_exp;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ir, input logic [31:0] alu, input logic [31:0] lmd);
        ir_in  = ir;
        alu_in = alu;
        lmd_in = lmd;
    endtask

    task automatic check_all_zero(input string name);
        for (int a = 0; a < 32; a++) begin
            rs_addr = 5'(a);
            rt_addr = 5'(31 - a);
            #1;
            check({name, "_rs"}, rs_data, 32'h0);
            check({name, "_rt"}, rt_data, 32'h0);
        end
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        exp_cnt = '0;
        rst     = 1'b1;
        rs_addr = '0;
        rt_addr = '0;
        drive(32'h012A4020, 32'h55, 32'h0);

        //            ir            alu           lmd           we    chk   addr   data          rd     rd_exp
        vecs[0]  = '{32'h012A4020, 32'h00000055, 32'h00000000, 1'b1, 1'b1, 5'd8,  32'h00000055, 5'd8,  32'h00000055};
        vecs[1]  = '{32'h8C430004, 32'h00001234, 32'hDEADBEEF, 1'b1, 1'b1, 5'd3,  32'hDEADBEEF, 5'd3,  32'hDEADBEEF};
        vecs[2]  = '{32'h20640007, 32'h00000007, 32'h00000000, 1'b1, 1'b1, 5'd4,  32'h00000007, 5'd4,  32'h00000007};
        vecs[3]  = '{32'hAC430000, 32'h00000099, 32'h00000000, 1'b0, 1'b0, 5'd0,  32'h00000000, 5'd3,  32'hDEADBEEF};
        vecs[4]  = '{32'h10000003, 32'h00000011, 32'h00000000, 1'b0, 1'b0, 5'd0,  32'h00000000, 5'd0,  32'h00000000};
        vecs[5]  = '{32'h08000010, 32'h00000022, 32'h00000000, 1'b0, 1'b0, 5'd0,  32'h00000000, 5'd8,  32'h00000055};
        vecs[6]  = '{32'h00000020, 32'h0000FFFF, 32'h00000000, 1'b0, 1'b1, 5'd0,  32'h0000FFFF, 5'd0,  32'h00000000};
        vecs[7]  = '{32'h00000000, 32'h00000000, 32'h00000000, 1'b0, 1'b1, 5'd0,  32'h00000000, 5'd4,  32'h00000007};
        vecs[8]  = '{32'h3529000F, 32'h0000FFFF, 32'h00000000, 1'b1, 1'b1, 5'd9,  32'h0000FFFF, 5'd9,  32'h0000FFFF};
        vecs[9]  = '{32'h3C0A1234, 32'h12340000, 32'hCAFEF00D, 1'b1, 1'b1, 5'd10, 32'h12340000, 5'd10, 32'h12340000};
        vecs[10] = '{32'h400B0000, 32'h00000033, 32'h00000000, 1'b0, 1'b0, 5'd0,  32'h00000000, 5'd11, 32'h00000000};
        vecs[11] = '{32'h1C0C0000, 32'h00000044, 32'h00000000, 1'b0, 1'b0, 5'd0,  32'h00000000, 5'd12, 32'h00000000};

        tick();
        tick();
        rst = 1'b0;
        drive(32'h0, 32'h0, 32'h0);
        check("rst_we", 32'(wb_we), 32'h0);
        check("rst_addr", 32'(wb_addr), 32'h0);
        check("rst_data", wb_data, 32'h0);
        check("rst_cnt", 32'(retire_cnt), 32'h0);
        check_all_zero("rst_regs");

        // Table: capture, check pending write, then commit behind a NOP and read back.
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].ir, vecs[i].alu, vecs[i].lmd);
            tick();
            check($sformatf("v%0d_we", i), 32'(wb_we), 32'(vecs[i].we));
            if (vecs[i].chk_ad) begin
                check($sformatf("v%0d_addr", i), 32'(wb_addr), 32'(vecs[i].addr));
                check($sformatf("v%0d_data", i), wb_data, vecs[i].data);
            end
            drive(32'h0, 32'h0, 32'h0);
            tick();
            if (vecs[i].ir != 32'h0) exp_cnt = exp_cnt + 4'd1;
            rs_addr = vecs[i].rd;
            rt_addr = vecs[i].rd;
            #1;
            check($sformatf("v%0d_rs", i), rs_data, vecs[i].rd_exp);
            check($sformatf("v%0d_rt", i), rt_data, vecs[i].rd_exp);
            check($sformatf("v%0d_cnt", i), 32'(retire_cnt), 32'(exp_cnt));
        end

        // Same-cycle read of the register being written.
        drive(32'h00A52820, 32'hA5A5A5A5, 32'h0);
        tick();
        drive(32'h0, 32'h0, 32'h0);
        rs_addr = 5'd5;
        rt_addr = 5'd5;
        #1;
        check("byp_we", 32'(wb_we), 32'h1);
`ifdef WB_BYPASS_EN
        check("byp_rs_pre", rs_data, 32'hA5A5A5A5);
        check("byp_rt_pre", rt_data, 32'hA5A5A5A5);
`else
        check("byp_rs_pre", rs_data, 32'h0);
        check("byp_rt_pre", rt_data, 32'h0);
`endif
        tick();
        exp_cnt = exp_cnt + 4'd1;
        check("byp_rs_post", rs_data, 32'hA5A5A5A5);
        check("byp_rt_post", rt_data, 32'hA5A5A5A5);

        // Counter wrap: bring the 4-bit count to 16 with back-to-back sw.
        for (int k = 0; k < 16 - int'(exp_cnt); k++) begin
            drive(32'hAC430000, 32'h0, 32'h0);
            tick();
        end
        drive(32'h0, 32'h0, 32'h0);
        tick();
        check("wrap_cnt", 32'(retire_cnt), 32'h0);
        tick();
        check("wrap_nop_cnt", 32'(retire_cnt), 32'h0);

        // Reset while add $7 is pending: write dropped, not counted.
        drive(32'h00E73820, 32'h00000077, 32'h0);
        tick();
        check("midrst_pend_we", 32'(wb_we), 32'h1);
        check("midrst_pend_addr", 32'(wb_addr), 32'h7);
        rst = 1'b1;
        drive(32'h0, 32'h0, 32'h0);
        tick();
        rst = 1'b0;
        rs_addr = 5'd7;
        rt_addr = 5'd7;
        #1;
        check("midrst_r7", rs_data, 32'h0);
        check("midrst_cnt", 32'(retire_cnt), 32'h0);
        check("midrst_we", 32'(wb_we), 32'h0);
        tick();
        check("midrst_r7_after", rt_data, 32'h0);
        check("midrst_cnt_after", 32'(retire_cnt), 32'h0);
        check_all_zero("midrst_regs");

        // First capture after reset happens at the first edge with rst low.
        drive(32'h8C430004, 32'h0, 32'h13579BDF);
        tick();
        drive(32'h0, 32'h0, 32'h0);
        check("post_rst_we", 32'(wb_we), 32'h1);
        check("post_rst_data", wb_data, 32'h13579BDF);
        tick();
        rs_addr = 5'd3;
        #1;
        check("post_rst_r3", rs_data, 32'h13579BDF);
        check("post_rst_cnt", 32'(retire_cnt), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
